// File: rtl/al4s3b_wb_arbiter.sv
// Two-master Wishbone arbiter with round-robin grant and a per-transaction ACK watchdog.
// A timed-out transaction is terminated toward the master with ACK+ERR and a fixed read value.
module al4s3b_wb_arbiter #(
  parameter int unsigned           CNTR_WIDTH         = 8,
  parameter logic [CNTR_WIDTH-1:0] TIMEOUT_CYCLES     = 8'd255,
  parameter logic [31:0]           TIMEOUT_READ_VALUE = 32'hBADFABAC
) (
  input  logic        WB_CLK,
  input  logic        WB_RST,
  input  logic [16:0] M0_ADR,
  input  logic        M0_CYC,
  input  logic        M0_STB,
  input  logic        M0_WE,
  input  logic [3:0]  M0_BYTE_STB,
  input  logic [31:0] M0_WR_DAT,
  output logic [31:0] M0_RD_DAT,
  output logic        M0_ACK,
  output logic        M0_ERR,
  input  logic [16:0] M1_ADR,
  input  logic        M1_CYC,
  input  logic        M1_STB,
  input  logic        M1_WE,
  input  logic [3:0]  M1_BYTE_STB,
  input  logic [31:0] M1_WR_DAT,
  output logic [31:0] M1_RD_DAT,
  output logic        M1_ACK,
  output logic        M1_ERR,
  output logic [16:0] WBs_ADR,
  output logic        WBs_CYC,
  output logic        WBs_STB,
  output logic        WBs_WE,
  output logic        WBs_RD,
  output logic [3:0]  WBs_BYTE_STB,
  output logic [31:0] WBs_WR_DAT,
  input  logic [31:0] WBs_RD_DAT,
  input  logic        WBs_ACK,
  output logic [1:0]  Arb_Gnt,
  output logic        Timeout_Sts,
  input  logic        Timeout_Clr
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_TOUT} state_e;

  localparam logic [CNTR_WIDTH-1:0] TMO_LAST = TIMEOUT_CYCLES - CNTR_WIDTH'(1);

  state_e                state_q, state_d;
  logic [1:0]            gnt_q, gnt_d;
  logic                  ptr_q, ptr_d;   // 1: M1 was granted last
  logic [CNTR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  sts_q, sts_d;

  logic req0, req1, sel_m1, sel_cyc, sel_stb, sel_we;

  assign req0    = M0_CYC & M0_STB;
  assign req1    = M1_CYC & M1_STB;
  assign sel_m1  = gnt_q[1];
  assign sel_cyc = sel_m1 ? M1_CYC : M0_CYC;
  assign sel_stb = sel_m1 ? M1_STB : M0_STB;
  assign sel_we  = sel_m1 ? M1_WE  : M0_WE;

  assign Arb_Gnt     = gnt_q;
  assign Timeout_Sts = sts_q;

  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ptr_q   <= 1'b1;
      cnt_q   <= '0;
      sts_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sts_q   <= sts_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 | req1) begin
          state_d = ST_BUSY;
          cnt_d   = '0;
          if (req0 & req1) gnt_d = ptr_q ? 2'b01 : 2'b10;
          else             gnt_d = req1  ? 2'b10 : 2'b01;
        end
      end
      ST_BUSY: begin
        // ACK and master abort both end the transaction; neither reaches TOUT
        if (WBs_ACK || !sel_cyc) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          ptr_d   = gnt_q[1];
        end else if (cnt_q == TMO_LAST) begin
          state_d = ST_TOUT;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNTR_WIDTH'(1);
        end
      end
      ST_TOUT: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        ptr_d   = gnt_q[1];
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
    sts_d = Timeout_Clr ? 1'b0 : ((state_q == ST_TOUT) ? 1'b1 : sts_q);
  end

  always_comb begin
    WBs_ADR      = '0;
    WBs_CYC      = 1'b0;
    WBs_STB      = 1'b0;
    WBs_WE       = 1'b0;
    WBs_RD       = 1'b0;
    WBs_BYTE_STB = '0;
    WBs_WR_DAT   = '0;
    M0_RD_DAT    = '0;
    M0_ACK       = 1'b0;
    M0_ERR       = 1'b0;
    M1_RD_DAT    = '0;
    M1_ACK       = 1'b0;
    M1_ERR       = 1'b0;
    case (state_q)
      ST_BUSY: begin
        WBs_ADR      = sel_m1 ? M1_ADR      : M0_ADR;
        WBs_CYC      = sel_cyc;
        WBs_STB      = sel_stb;
        WBs_WE       = sel_we;
        WBs_RD       = sel_cyc & sel_stb & ~sel_we;
        WBs_BYTE_STB = sel_m1 ? M1_BYTE_STB : M0_BYTE_STB;
        WBs_WR_DAT   = sel_m1 ? M1_WR_DAT   : M0_WR_DAT;
        if (gnt_q[0]) begin
          M0_RD_DAT = WBs_RD_DAT;
          M0_ACK    = WBs_ACK;
        end
        if (gnt_q[1]) begin
          M1_RD_DAT = WBs_RD_DAT;
          M1_ACK    = WBs_ACK;
        end
      end
      ST_TOUT: begin
        if (gnt_q[0]) begin
          M0_RD_DAT = TIMEOUT_READ_VALUE;
          M0_ACK    = 1'b1;
          M0_ERR    = 1'b1;
        end
        if (gnt_q[1]) begin
          M1_RD_DAT = TIMEOUT_READ_VALUE;
          M1_ACK    = 1'b1;
          M1_ERR    = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_al4s3b_wb_arbiter.sv
// Directed-vector bench for al4s3b_wb_arbiter with the watchdog shortened to 4 cycles.
module tb_al4s3b_wb_arbiter;

  logic        WB_CLK = 1'b0;
  logic        WB_RST;
  logic [16:0] M0_ADR, M1_ADR;
  logic        M0_CYC, M0_STB, M0_WE, M1_CYC, M1_STB, M1_WE;
  logic [3:0]  M0_BYTE_STB, M1_BYTE_STB;
  logic [31:0] M0_WR_DAT, M1_WR_DAT;
  logic [31:0] M0_RD_DAT, M1_RD_DAT;
  logic        M0_ACK, M0_ERR, M1_ACK, M1_ERR;
  logic [16:0] WBs_ADR;
  logic        WBs_CYC, WBs_STB, WBs_WE, WBs_RD;
  logic [3:0]  WBs_BYTE_STB;
  logic [31:0] WBs_WR_DAT, WBs_RD_DAT;
  logic        WBs_ACK;
  logic [1:0]  Arb_Gnt;
  logic        Timeout_Sts, Timeout_Clr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 WB_CLK = ~WB_CLK;

  al4s3b_wb_arbiter #(
    .CNTR_WIDTH        (8),
    .TIMEOUT_CYCLES    (8'd4),
    .TIMEOUT_READ_VALUE(32'hBADFABAC)
  ) dut (
    .WB_CLK(WB_CLK), .WB_RST(WB_RST),
    .M0_ADR(M0_ADR), .M0_CYC(M0_CYC), .M0_STB(M0_STB), .M0_WE(M0_WE),
    .M0_BYTE_STB(M0_BYTE_STB), .M0_WR_DAT(M0_WR_DAT), .M0_RD_DAT(M0_RD_DAT),
    .M0_ACK(M0_ACK), .M0_ERR(M0_ERR),
    .M1_ADR(M1_ADR), .M1_CYC(M1_CYC), .M1_STB(M1_STB), .M1_WE(M1_WE),
    .M1_BYTE_STB(M1_BYTE_STB), .M1_WR_DAT(M1_WR_DAT), .M1_RD_DAT(M1_RD_DAT),
    .M1_ACK(M1_ACK), .M1_ERR(M1_ERR),
    .WBs_ADR(WBs_ADR), .WBs_CYC(WBs_CYC), .WBs_STB(WBs_STB), .WBs_WE(WBs_WE),
    .WBs_RD(WBs_RD), .WBs_BYTE_STB(WBs_BYTE_STB), .WBs_WR_DAT(WBs_WR_DAT),
    .WBs_RD_DAT(WBs_RD_DAT), .WBs_ACK(WBs_ACK),
    .Arb_Gnt(Arb_Gnt), .Timeout_Sts(Timeout_Sts), .Timeout_Clr(Timeout_Clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge WB_CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge WB_CLK);
  endtask

  task automatic m0_req(input logic on, input logic we, input logic [16:0] adr);
    M0_CYC = on; M0_STB = on; M0_WE = we; M0_ADR = adr;
  endtask

  task automatic m1_req(input logic on, input logic we, input logic [16:0] adr);
    M1_CYC = on; M1_STB = on; M1_WE = we; M1_ADR = adr;
  endtask

  task automatic do_reset();
    nxt();
    WB_RST = 1'b1;
    m0_req(1'b0, 1'b0, '0);
    m1_req(1'b0, 1'b0, '0);
    WBs_ACK = 1'b0;
    nxt();
    WB_RST = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] exp_g;
    WB_RST = 1'b1;
    M0_ADR = '0; M0_CYC = 0; M0_STB = 0; M0_WE = 0; M0_BYTE_STB = 4'hF; M0_WR_DAT = '0;
    M1_ADR = '0; M1_CYC = 0; M1_STB = 0; M1_WE = 0; M1_BYTE_STB = 4'hF; M1_WR_DAT = '0;
    WBs_RD_DAT = '0; WBs_ACK = 0; Timeout_Clr = 0;
    repeat (2) nxt();
    WB_RST = 1'b0;
    smp();
    check("rst_gnt", Arb_Gnt, 0);
    check("rst_cyc", WBs_CYC, 0);
    check("rst_sts", Timeout_Sts, 0);
    check("rst_m0ack", M0_ACK, 0);

    // single read, ACK two cycles after CYC
    nxt(); m0_req(1, 0, 17'h00000); smp();
    check("rd_idle_gnt", Arb_Gnt, 0);
    check("rd_idle_cyc", WBs_CYC, 0);
    nxt(); smp();
    check("rd_busy_gnt", Arb_Gnt, 2'b01);
    check("rd_busy_cyc", WBs_CYC, 1);
    check("rd_busy_rd", WBs_RD, 1);
    check("rd_busy_ack", M0_ACK, 0);
    nxt(); smp();
    nxt(); WBs_ACK = 1; WBs_RD_DAT = 32'h0000_1234; smp();
    check("rd_ack", M0_ACK, 1);
    check("rd_dat", M0_RD_DAT, 32'h0000_1234);
    check("rd_m1ack", M1_ACK, 0);
    check("rd_m1dat", M1_RD_DAT, 0);
    nxt(); WBs_ACK = 0; m0_req(0, 0, '0); smp();
    check("rd_end_gnt", Arb_Gnt, 0);
    check("rd_end_dat", M0_RD_DAT, 0);

    // contention with both masters always requesting
    do_reset();
    nxt(); m0_req(1, 0, 17'h00010); m1_req(1, 0, 17'h00020); smp();
    check("rr_idle0", Arb_Gnt, 0);
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
      nxt(); WBs_ACK = 0; smp();
      check($sformatf("rr%0d_gnt", i), Arb_Gnt, exp_g);
      check($sformatf("rr%0d_adr", i), WBs_ADR, exp_g[1] ? 17'h00020 : 17'h00010);
      nxt(); WBs_ACK = 1; smp();
      check($sformatf("rr%0d_ack", i), {M1_ACK, M0_ACK}, exp_g);
      nxt(); WBs_ACK = 0; smp();
      check($sformatf("rr%0d_idle", i), Arb_Gnt, 0);
    end
    nxt(); m0_req(0, 0, '0); m1_req(0, 0, '0);
    nxt(); nxt();

    // M1 write pass-through
    M1_WR_DAT = 32'hA5A5_5A5A; M1_BYTE_STB = 4'b0011;
    nxt(); m1_req(1, 1, 17'h01008); smp();
    nxt(); smp();
    check("wr_gnt", Arb_Gnt, 2'b10);
    check("wr_adr", WBs_ADR, 17'h01008);
    check("wr_dat", WBs_WR_DAT, 32'hA5A5_5A5A);
    check("wr_bs", WBs_BYTE_STB, 4'b0011);
    check("wr_we", WBs_WE, 1);
    check("wr_rd", WBs_RD, 0);
    nxt(); WBs_ACK = 1; smp();
    check("wr_ack", {M1_ACK, M0_ACK}, 2'b10);
    nxt(); WBs_ACK = 0; m1_req(0, 0, '0);
    nxt();

    // timeout on an M0 read
    nxt(); m0_req(1, 0, 17'h00100); smp();
    for (int i = 0; i < 4; i++) begin
      nxt(); smp();
      check($sformatf("to_busy%0d_cyc", i), WBs_CYC, 1);
      check($sformatf("to_busy%0d_err", i), M0_ERR, 0);
    end
    nxt(); smp();
    check("to_ack", M0_ACK, 1);
    check("to_err", M0_ERR, 1);
    check("to_dat", M0_RD_DAT, 32'hBADFABAC);
    check("to_cyc", WBs_CYC, 0);
    check("to_gnt", Arb_Gnt, 2'b01);
    nxt(); m0_req(0, 0, '0); smp();
    check("to_sts_set", Timeout_Sts, 1);
    check("to_idle_gnt", Arb_Gnt, 0);
    check("to_idle_err", M0_ERR, 0);
    nxt(); Timeout_Clr = 1; smp();
    nxt(); Timeout_Clr = 0; smp();
    check("to_sts_clr", Timeout_Sts, 0);

    // reset in the middle of an M0 transaction
    nxt(); m0_req(1, 0, 17'h1FFFC); smp();
    nxt(); smp();
    check("rs_busy_gnt", Arb_Gnt, 2'b01);
    nxt(); WB_RST = 1; WBs_RD_DAT = 32'hDEAD_BEEF; smp();
    nxt(); WB_RST = 0; m1_req(1, 0, 17'h00040); smp();
    check("rs_gnt", Arb_Gnt, 0);
    check("rs_cyc", WBs_CYC, 0);
    check("rs_adr", WBs_ADR, 0);
    check("rs_ack", M0_ACK, 0);
    check("rs_dat", M0_RD_DAT, 0);
    nxt(); smp();
    check("rs_first_win", Arb_Gnt, 2'b01);
    nxt(); m0_req(0, 0, '0); m1_req(0, 0, '0);
    nxt(); nxt();

    // M1 abort in its second BUSY cycle
    nxt(); m1_req(1, 0, 17'h00080); smp();
    nxt(); smp();
    check("ab_gnt", Arb_Gnt, 2'b10);
    nxt(); m1_req(0, 0, 17'h00080); smp();
    check("ab_drop_ack", {M1_ERR, M1_ACK}, 0);
    nxt(); smp();
    check("ab_idle_gnt", Arb_Gnt, 0);
    check("ab_idle_ack", {M1_ERR, M1_ACK}, 0);
    check("ab_sts", Timeout_Sts, 0);

    // timeout coinciding with a clear pulse
    nxt(); m0_req(1, 0, 17'h00200); smp();
    repeat (4) begin nxt(); smp(); end
    nxt(); Timeout_Clr = 1; smp();
    check("col_err", M0_ERR, 1);
    nxt(); Timeout_Clr = 0; m0_req(0, 0, '0); smp();
    check("col_sts", Timeout_Sts, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
